// File: rtl/fp_pkg.sv
// Shared definitions for the FP write-back collector: register selects,
// FSM states and the buffered {sel,data} entry.
package fp_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_R1   = 2'b01;
  localparam logic [1:0] SEL_R2   = 2'b10;
  localparam logic [1:0] SEL_R3   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [0:15] data;
  } wb_entry_t;

  function automatic logic sel_is_reg(input logic [1:0] sel);
    return (sel == SEL_R1) || (sel == SEL_R2) || (sel == SEL_R3);
  endfunction

endpackage

// File: rtl/fpwb_fifo.sv
// Write-back FIFO; a push into a full FIFO is accepted when a pop frees a slot
// in the same cycle.
module fpwb_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  wb_entry_t i_din,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  wb_entry_t   r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/fpwb.sv
// FP write-back collector: edge-detects AWP strobes, buffers results for
// r1..r3, latches flags and interrupts, and reports instruction completion.
module fpwb
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        __clk,
  input  logic        clr_,
  input  logic [0:15] zp,
  input  logic        s_fp_,
  input  logic        lpa,
  input  logic        lpb,
  input  logic        ustr0_fp_,
  input  logic        fi0_,
  input  logic        fi1_,
  input  logic        fi2_,
  input  logic        fi3_,
  input  logic        ekc_fp_,
  input  logic        rf_rdy,
  input  logic [0:3]  irq_ack,
  input  logic        done_ack,
  output logic        rf_we,
  output logic [0:1]  rf_a,
  output logic [0:15] rf_d,
  output logic        flags_we,
  output logic [0:3]  flags,
  output logic [0:3]  irq_pend,
  output logic        fp_done,
  output logic        ovf
);

  localparam int SB_SFP  = 0;
  localparam int SB_USTR = 1;
  localparam int SB_EKC  = 6;

  logic [0:6]  w_strb;
  logic [0:6]  r_strb_cur;
  logic [0:6]  r_strb_prev;
  logic [0:6]  w_ev;
  logic [0:3]  w_fi_ev;
  logic        r_armed;
  logic [0:15] r_zp;
  logic [1:0]  r_sel;

  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  wb_entry_t   w_din;
  wb_entry_t   w_head;

  logic [0:3]  r_flags;
  logic        r_flags_we;
  logic [0:3]  r_irq;
  logic        r_ovf;

  state_t      r_state;
  state_t      w_state_nxt;

  assign w_strb = {s_fp_, ustr0_fp_, fi0_, fi1_, fi2_, fi3_, ekc_fp_};

  // The first edge after reset loads both history stages with the live level,
  // so a strobe held low across reset release never looks like a new edge.
  always_ff @(posedge __clk or negedge clr_) begin
    if (!clr_) begin
      r_strb_cur  <= '1;
      r_strb_prev <= '1;
      r_armed     <= 1'b0;
      r_zp        <= '0;
      r_sel       <= SEL_NONE;
    end else begin
      r_strb_cur  <= w_strb;
      r_strb_prev <= r_armed ? r_strb_cur : w_strb;
      r_armed     <= 1'b1;
      r_zp        <= zp;
      r_sel       <= {lpb, lpa};
    end
  end

  assign w_ev    = r_strb_prev & ~r_strb_cur;
  assign w_fi_ev = w_ev[2:5];

  assign w_push     = w_ev[SB_SFP] & sel_is_reg(r_sel);
  assign w_din.sel  = r_sel;
  assign w_din.data = r_zp;
  assign w_pop      = ~w_empty & rf_rdy;

  fpwb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (__clk),
    .rst_n   (clr_),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A push while already DONE is still buffered but flagged as a protocol error.
  always_ff @(posedge __clk or negedge clr_) begin
    if (!clr_) begin
      r_flags    <= '0;
      r_flags_we <= 1'b0;
      r_irq      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_flags_we <= w_ev[SB_USTR];
      if (w_ev[SB_USTR]) r_flags <= r_zp[0:3];
      r_irq <= w_fi_ev | (r_irq & ~irq_ack);
      if ((w_push & w_full & ~w_pop) | (w_push & (r_state == ST_DONE))) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge __clk or negedge clr_) begin
    if (!clr_) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ev[SB_EKC])                        w_state_nxt = ST_DRAIN;
        else if (w_ev[SB_SFP] | w_ev[SB_USTR])   w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_ev[SB_EKC]) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_empty & ~w_push) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (done_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign rf_we    = ~w_empty;
  assign rf_a     = w_empty ? 2'b00 : w_head.sel;
  assign rf_d     = w_empty ? 16'h0000 : w_head.data;
  assign flags_we = r_flags_we;
  assign flags    = r_flags;
  assign irq_pend = r_irq;
  assign fp_done  = (r_state == ST_DONE);
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_fpwb.sv
// Randomised and scenario-driven bench for fpwb, checked every cycle against
// a queue-based reference model of the collector's behaviour.
module tb_fpwb;

  localparam int DEPTH = 4;

  localparam logic [0:6] STRB_IDLE = 7'b1111111;
  localparam logic [0:6] STRB_SFP  = 7'b0111111;
  localparam logic [0:6] STRB_USTR = 7'b1011111;
  localparam logic [0:6] STRB_FI2  = 7'b1111011;
  localparam logic [0:6] STRB_EKC  = 7'b1111110;
  localparam logic [0:6] STRB_ALL  = 7'b0000000;

  localparam logic [1:0] R1 = 2'b01;
  localparam logic [1:0] R2 = 2'b10;
  localparam logic [1:0] R3 = 2'b11;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  typedef struct packed {
    logic [0:6]  strb;
    logic [1:0]  sel;
    logic [0:15] z;
  } sample_t;

  logic        clock;
  logic        clrN;
  logic [0:15] zpBus;
  logic        sFpN, lpa, lpb, ustrN, ekcN, rfRdy, doneAck;
  logic [0:3]  fiN;
  logic [0:3]  irqAck;
  logic        rfWe, flagsWe, fpDone, ovf;
  logic [0:1]  rfA;
  logic [0:15] rfD;
  logic [0:3]  flags, irqPend;

  int assertCount = 0;
  int failCount = 0;
  int weCycles = 0;
  logic [1:0]  popA[$];
  logic [15:0] popD[$];

  logic [17:0] mq[$];
  logic [0:3]  mFlags, mIrq;
  logic        mFlagsWe, mOvf;
  int          mPhase;
  int          edgesSinceReset;
  sample_t     lastSamp, prevSamp;

  fpwb #(.DEPTH(DEPTH)) dut (
    .__clk     (clock),
    .clr_      (clrN),
    .zp        (zpBus),
    .s_fp_     (sFpN),
    .lpa       (lpa),
    .lpb       (lpb),
    .ustr0_fp_ (ustrN),
    .fi0_      (fiN[0]),
    .fi1_      (fiN[1]),
    .fi2_      (fiN[2]),
    .fi3_      (fiN[3]),
    .ekc_fp_   (ekcN),
    .rf_rdy    (rfRdy),
    .irq_ack   (irqAck),
    .done_ack  (doneAck),
    .rf_we     (rfWe),
    .rf_a      (rfA),
    .rf_d      (rfD),
    .flags_we  (flagsWe),
    .flags     (flags),
    .irq_pend  (irqPend),
    .fp_done   (fpDone),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mFlags = '0;
    mIrq = '0;
    mFlagsWe = 1'b0;
    mOvf = 1'b0;
    mPhase = PH_IDLE;
    edgesSinceReset = 0;
    lastSamp = '1;
    prevSamp = '1;
  endtask

  // One clock edge of the reference: actions come from falling strobe levels
  // seen in the two previous samples, both taken after reset release.
  task automatic modelEdge();
    sample_t    nowSamp;
    logic [0:6] ev;
    logic       wasEmpty, wasFull, pop, push;
    nowSamp.strb = {sFpN, ustrN, fiN, ekcN};
    nowSamp.sel  = {lpb, lpa};
    nowSamp.z    = zpBus;
    for (int b = 0; b < 7; b++)
      ev[b] = (edgesSinceReset >= 2) && prevSamp.strb[b] && !lastSamp.strb[b];
    wasEmpty = (mq.size() == 0);
    wasFull  = (mq.size() == DEPTH);
    pop  = !wasEmpty && rfRdy;
    push = ev[0] && (lastSamp.sel != 2'b00);
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (!wasFull || pop) mq.push_back({lastSamp.sel, lastSamp.z});
      else mOvf = 1'b1;
      if (mPhase == PH_DONE) mOvf = 1'b1;
    end
    mFlagsWe = ev[1];
    if (ev[1]) mFlags = lastSamp.z[0:3];
    for (int i = 0; i < 4; i++) begin
      if (ev[2+i]) mIrq[i] = 1'b1;
      else if (irqAck[i]) mIrq[i] = 1'b0;
    end
    case (mPhase)
      PH_IDLE:  if (ev[6]) mPhase = PH_DRAIN; else if (ev[0] || ev[1]) mPhase = PH_RUN;
      PH_RUN:   if (ev[6]) mPhase = PH_DRAIN;
      PH_DRAIN: if (wasEmpty && !push) mPhase = PH_DONE;
      PH_DONE:  if (doneAck) mPhase = PH_IDLE;
      default:  mPhase = PH_IDLE;
    endcase
    prevSamp = lastSamp;
    lastSamp = nowSamp;
    if (edgesSinceReset < 2) edgesSinceReset++;
  endtask

  task automatic compareAll();
    logic [17:0] head;
    head = (mq.size() > 0) ? mq[0] : 18'h0;
    checkOutput("rfWe",     32'(rfWe),     32'(mq.size() > 0));
    checkOutput("rfA",      32'(rfA),      32'(head[17:16]));
    checkOutput("rfD",      32'(rfD),      32'(head[15:0]));
    checkOutput("flagsWe",  32'(flagsWe),  32'(mFlagsWe));
    checkOutput("flags",    32'(flags),    32'(mFlags));
    checkOutput("irqPend",  32'(irqPend),  32'(mIrq));
    checkOutput("fpDone",   32'(fpDone),   32'(mPhase == PH_DONE));
    checkOutput("ovf",      32'(ovf),      32'(mOvf));
  endtask

  task automatic applyStimulus(input logic [0:6] strb, input logic [1:0] sel, input logic [0:15] z,
                               input logic rdy, input logic [0:3] ack, input logic dack);
    @(negedge clock);
    sFpN = strb[0];
    ustrN = strb[1];
    fiN = strb[2:5];
    ekcN = strb[6];
    {lpb, lpa} = sel;
    zpBus = z;
    rfRdy = rdy;
    irqAck = ack;
    doneAck = dack;
    if (rfWe && rfRdy) begin
      popA.push_back(rfA);
      popD.push_back(rfD);
    end
    @(posedge clock);
    if (clrN) modelEdge();
    else modelReset();
    #1;
    compareAll();
    if (rfWe) weCycles++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(STRB_IDLE, 2'b00, 16'h0, rdy, 4'h0, 1'b0);
  endtask

  task automatic pushWord(input logic [1:0] sel, input logic [0:15] z, input logic rdy);
    applyStimulus(STRB_SFP, sel, z, rdy, 4'h0, 1'b0);
    applyStimulus(STRB_IDLE, sel, z, rdy, 4'h0, 1'b0);
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (!fpDone && n < limit) begin
      applyStimulus(STRB_IDLE, 2'b00, 16'h0, 1'b1, 4'h0, 1'b0);
      n++;
    end
    checkOutput("doneReached", 32'(fpDone), 32'd1);
  endtask

  task automatic finishInstr();
    applyStimulus(STRB_EKC, 2'b00, 16'h0, 1'b1, 4'h0, 1'b0);
    applyStimulus(STRB_EKC, 2'b00, 16'h0, 1'b1, 4'h0, 1'b0);
    waitDone(40);
    applyStimulus(STRB_IDLE, 2'b00, 16'h0, 1'b1, 4'h0, 1'b1);
    checkOutput("doneCleared", 32'(fpDone), 32'd0);
  endtask

  task automatic asyncReset(input logic [0:6] strb);
    @(negedge clock);
    clrN = 1'b0;
    #1;
    modelReset();
    compareAll();
    checkOutput("rstOuts", 32'({rfWe, rfA, rfD, flagsWe, flags, irqPend, fpDone, ovf}), 32'd0);
    applyStimulus(strb, 2'b00, 16'h0, 1'b0, 4'h0, 1'b0);
    applyStimulus(strb, 2'b00, 16'h0, 1'b0, 4'h0, 1'b0);
    clrN = 1'b1;
  endtask

  task automatic clearObs();
    popA.delete();
    popD.delete();
    weCycles = 0;
  endtask

  initial begin
    logic [0:6] rStrb;
    logic       rdy;
    logic [0:3] ack;
    int         thr[7];

    clrN = 1'b0;
    {sFpN, ustrN, ekcN} = 3'b111;
    fiN = 4'hF;
    {lpb, lpa} = 2'b00;
    zpBus = 16'h0;
    rfRdy = 1'b0;
    irqAck = 4'h0;
    doneAck = 1'b0;
    modelReset();

    applyStimulus(STRB_IDLE, 2'b00, 16'h0, 1'b0, 4'h0, 1'b0);
    applyStimulus(STRB_IDLE, 2'b00, 16'h0, 1'b0, 4'h0, 1'b0);
    checkOutput("rstOuts", 32'({rfWe, rfA, rfD, flagsWe, flags, irqPend, fpDone, ovf}), 32'd0);
    clrN = 1'b1;
    idle(3, 1'b1);

    // Single write with a strobe held low for three cycles.
    clearObs();
    for (int i = 0; i < 3; i++) applyStimulus(STRB_SFP, R1, 16'h1234, 1'b1, 4'h0, 1'b0);
    idle(4, 1'b1);
    checkOutput("singleWeCycles", 32'(weCycles), 32'd1);
    checkOutput("singlePops", 32'(popA.size()), 32'd1);
    if (popA.size() > 0) begin
      checkOutput("singleA", 32'(popA[0]), 32'd1);
      checkOutput("singleD", 32'(popD[0]), 32'h1234);
    end
    applyStimulus(STRB_EKC, 2'b00, 16'h0, 1'b1, 4'h0, 1'b0);
    applyStimulus(STRB_EKC, 2'b00, 16'h0, 1'b1, 4'h0, 1'b0);
    waitDone(20);
    idle(3, 1'b1);
    checkOutput("doneHeld", 32'(fpDone), 32'd1);
    applyStimulus(STRB_IDLE, 2'b00, 16'h0, 1'b1, 4'h0, 1'b1);
    checkOutput("doneAckFall", 32'(fpDone), 32'd0);

    // Three writes under backpressure, released after the done strobe.
    clearObs();
    pushWord(R1, 16'hAAAA, 1'b0);
    pushWord(R2, 16'h5555, 1'b0);
    pushWord(R3, 16'h0F0F, 1'b0);
    applyStimulus(STRB_EKC, 2'b00, 16'h0, 1'b0, 4'h0, 1'b0);
    applyStimulus(STRB_EKC, 2'b00, 16'h0, 1'b0, 4'h0, 1'b0);
    idle(2, 1'b0);
    checkOutput("bpNoEarlyDone", 32'(fpDone), 32'd0);
    checkOutput("bpHeadValid", 32'(rfWe), 32'd1);
    waitDone(20);
    checkOutput("bpPops", 32'(popA.size()), 32'd3);
    if (popA.size() == 3) begin
      checkOutput("bpA0", 32'(popA[0]), 32'd1);
      checkOutput("bpA1", 32'(popA[1]), 32'd2);
      checkOutput("bpA2", 32'(popA[2]), 32'd3);
      checkOutput("bpD0", 32'(popD[0]), 32'hAAAA);
      checkOutput("bpD1", 32'(popD[1]), 32'h5555);
      checkOutput("bpD2", 32'(popD[2]), 32'h0F0F);
    end
    applyStimulus(STRB_IDLE, 2'b00, 16'h0, 1'b1, 4'h0, 1'b1);

    // Fifth push into a full FIFO with no pop is dropped.
    asyncReset(STRB_IDLE);
    idle(2, 1'b0);
    clearObs();
    for (int i = 0; i < 5; i++) pushWord(2'((i % 3) + 1), 16'(16'h1000 + i), 1'b0);
    checkOutput("ovfSet", 32'(ovf), 32'd1);
    finishInstr();
    checkOutput("ovfKeptWords", 32'(popD.size()), 32'd4);
    if (popD.size() == 4) checkOutput("ovfLastKept", 32'(popD[3]), 32'h1003);

    // Fifth push coincident with a pop is kept.
    asyncReset(STRB_IDLE);
    idle(2, 1'b0);
    for (int i = 0; i < 4; i++) pushWord(2'((i % 3) + 1), 16'(16'h2000 + i), 1'b0);
    clearObs();
    applyStimulus(STRB_SFP, R2, 16'h2004, 1'b0, 4'h0, 1'b0);
    applyStimulus(STRB_IDLE, R2, 16'h2004, 1'b1, 4'h0, 1'b0);
    checkOutput("ovfCoincident", 32'(ovf), 32'd0);
    finishInstr();
    checkOutput("coinWords", 32'(popD.size()), 32'd5);
    if (popD.size() == 5) checkOutput("coinLast", 32'(popD[4]), 32'h2004);

    // Flag update bypasses the FIFO.
    clearObs();
    applyStimulus(STRB_USTR, 2'b00, 16'hA000, 1'b1, 4'h0, 1'b0);
    applyStimulus(STRB_IDLE, 2'b00, 16'h0, 1'b1, 4'h0, 1'b0);
    checkOutput("flagsWePulse", 32'(flagsWe), 32'd1);
    checkOutput("flagsValue", 32'(flags), 32'hA);
    applyStimulus(STRB_IDLE, 2'b00, 16'h0, 1'b1, 4'h0, 1'b0);
    checkOutput("flagsWeOneCycle", 32'(flagsWe), 32'd0);
    checkOutput("flagsNoWrite", 32'(weCycles), 32'd0);
    finishInstr();

    // Interrupt event beats a simultaneous ack; a later ack clears.
    applyStimulus(STRB_FI2, 2'b00, 16'h0, 1'b1, 4'h0, 1'b0);
    applyStimulus(STRB_IDLE, 2'b00, 16'h0, 1'b1, 4'b0010, 1'b0);
    checkOutput("irqSetWins", 32'(irqPend[2]), 32'd1);
    applyStimulus(STRB_IDLE, 2'b00, 16'h0, 1'b1, 4'b0010, 1'b0);
    checkOutput("irqAckClears", 32'(irqPend[2]), 32'd0);

    // Reset with buffered words and strobes held low across release.
    asyncReset(STRB_IDLE);
    idle(2, 1'b0);
    pushWord(R1, 16'h1111, 1'b0);
    pushWord(R3, 16'h3333, 1'b0);
    applyStimulus(STRB_ALL, R1, 16'hBEEF, 1'b0, 4'h0, 1'b0);
    asyncReset(STRB_ALL);
    clearObs();
    for (int i = 0; i < 4; i++) applyStimulus(STRB_ALL, R2, 16'hF00D, 1'b1, 4'h0, 1'b0);
    checkOutput("rstNoResidual", 32'(weCycles), 32'd0);
    checkOutput("rstNoEvent", 32'({fpDone, flagsWe, irqPend, ovf}), 32'd0);
    idle(3, 1'b1);

    // Random traffic with occasional resets.
    rStrb = STRB_IDLE;
    thr = '{5, 12, 15, 15, 15, 15, 20};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(499, 0) == 0) asyncReset(rStrb);
      for (int b = 0; b < 7; b++) begin
        if (!rStrb[b]) rStrb[b] = ($urandom_range(1, 0) == 1);
        else rStrb[b] = ($urandom_range(thr[b], 0) != 0);
      end
      if (((cyc / 200) % 2) == 0) rdy = ($urandom_range(3, 0) != 0);
      else rdy = ($urandom_range(3, 0) == 0);
      for (int i = 0; i < 4; i++) ack[i] = ($urandom_range(7, 0) == 0);
      applyStimulus(rStrb, 2'($urandom_range(3, 0)), 16'($urandom), rdy, ack,
                    ($urandom_range(3, 0) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fpwb.md
# fpwb

FP write-back collector, directly downstream of the AWP floating-point unit. It edge-detects the AWP's active-low strobes and buffers result words from the `zp` bus into a small FIFO. It drains those words to user registers r1..r3, captures ZMVC flag updates and latches the fi0..fi3 interrupt requests as sticky pending bits. It then signals instruction completion to the control unit only after every buffered result has been written back.

## Interface
Parameters:
- `DEPTH`, 4, write-back FIFO depth in words (power of two, ≥2)

Ports:
- `__clk`  in  1  system clock
- `clr_`  in  1  reset, asynchronous, active-low
- `zp`  in  [0:15]  AWP result bus
- `s_fp_`  in  1  AWP "ZP->W" strobe, active-low
- `lpa`, `lpb`  in  1 each  AWP register select; {lpb,lpa}: 01=r1, 10=r2, 11=r3, 00=none
- `ustr0_fp_`  in  1  AWP flag-set strobe, active-low
- `fi0_`..`fi3_`  in  1 each  AWP interrupt requests, active-low
- `ekc_fp_`  in  1  AWP done, active-low
- `rf_rdy`  in  1  register file accepts a write this cycle
- `irq_ack`  in  [0:3]  per-bit clear of pending interrupts
- `done_ack`  in  1  control unit consumed `fp_done`
- `rf_we`  out  1  register write valid
- `rf_a`  out  [0:1]  register number (1..3)
- `rf_d`  out  [0:15]  register data
- `flags_we`  out  1  one-cycle pulse: load ZMVC
- `flags`  out  [0:3]  Z,M,V,C
- `irq_pend`  out  [0:3]  sticky fi0..fi3 pending
- `fp_done`  out  1  instruction complete, held until `done_ack`
- `ovf`  out  1  sticky: a word was dropped on a full FIFO

## Operation
- Registered copies of all active-low strobes. An event is prev=1, cur=0 (falling edge). One event yields exactly one action regardless of strobe width.
- `s_fp_` event with select≠00: push {sel, zp} to the FIFO. With select=00: ignored.
- Full FIFO and a push: if a pop occurs the same cycle, the push is accepted. Otherwise the word is dropped and `ovf` is set. `ovf` clears only on reset.
- `rf_we` = FIFO not empty. `rf_a`/`rf_d` = head entry. Pop when `rf_we & rf_rdy`. Order is preserved.
- `ustr0_fp_` event: `flags` <= zp[0:3], and `flags_we` pulses for 1 cycle. Flags bypass the FIFO.
- `fiN_` event: `irq_pend[N]` <= 1. `irq_ack[N]` clears the bit. On the same cycle as a new event, set wins.
- FSM states:
  - IDLE: any `s_fp_`/`ustr0_fp_` event → RUN. An `ekc_fp_` event → DRAIN.
  - RUN: `ekc_fp_` event → DRAIN.
  - DRAIN: FIFO empty and no push this cycle → DONE. `s_fp_` events are still accepted here.
  - DONE: `fp_done`=1. `done_ack` → IDLE.
- `s_fp_` event while in DONE: push, and set `ovf`. It is a protocol error.

## Timing
- Reset (async, `clr_`=0) values:
  - `rf_we`=0, `rf_a`=0, `rf_d`=0, `flags_we`=0, `flags`=0, `irq_pend`=0, `fp_done`=0, `ovf`=0
  - FIFO empty, FSM in IDLE
  - strobe history regs=1, so no false event on release
- Reset mid-instruction discards all buffered words immediately.
- Strobe sampled low at edge k (history high) → entry visible, `rf_we`=1 after edge k+1. `flags_we` is high for the cycle after edge k+1.
- Throughput: 1 write/cycle with `rf_rdy`=1.
- DRAIN→DONE on the edge after the last pop. `fp_done` falls on the edge after `done_ack`.

## Structure
- Shared package `fp_pkg`: register-select encoding (R1=2'b01, R2=2'b10, R3=2'b11), FSM state enum, and the `{sel,data}` FIFO entry type of 18 bits.
- One sub-module `fpwb_fifo`: synchronous FIFO parameterised by `DEPTH`, with push/pop/full/empty and same-cycle push+pop when full.
- Edge detectors, flag/irq latches and FSM live in `fpwb`.

## Test plan
- Single write: `s_fp_` low 3 cycles, lpb/lpa=01, zp=16'h1234, `rf_rdy`=1. Expect exactly one `rf_we` with a=1, d=1234. Then `ekc_fp_` event → `fp_done`=1, held until `done_ack`.
- Triple write under backpressure: r1=AAAA, r2=5555, r3=0F0F pushed with `rf_rdy`=0. Then `ekc_fp_`, then `rf_rdy`=1. Expect writes in order 1,2,3, and `fp_done` only after the third pop.
- Overflow: DEPTH=4, 5 pushes with `rf_rdy`=0. Expect the 5th word dropped and `ovf`=1. A 5th push coincident with a pop must be kept and leave `ovf`=0.
- Flags: `ustr0_fp_` event with zp[0:3]=1010. Expect a 1-cycle `flags_we` and `flags`=1010. No `rf_we`.
- Interrupts: `fi2_` event on the same cycle as `irq_ack[2]`=1. Expect `irq_pend[2]`=1. A later ack with no event → 0.
- Reset mid-instruction: 2 words buffered, pulse `clr_` low. Expect all outputs at reset values with no residual writes, and no spurious events while strobes stay low across the reset release.
